// File: rtl/ibex_multdiv_arbiter.sv
// Two-requester arbiter in front of a shared slow multiplier/divider (optional perf counters: IBEX_MD_ARB_PERF_EN).
// Latency: grant, one or more BUSY cycles until md_valid_i, then result held in RESP; one IDLE bubble between ops.
// Backpressure: result is held in RESP until the owner asserts rsp_ready_i; no new grant is given meanwhile.

package ibex_pkg;
   typedef enum logic [1:0] {
      MD_OP_MULL = 2'b00,
      MD_OP_MULH = 2'b01,
      MD_OP_DIV  = 2'b10,
      MD_OP_REM  = 2'b11
   } md_op_e;
endpackage

module ibex_multdiv_arbiter
   import ibex_pkg::*;
#(
   parameter bit FixedPrio = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [1:0]          req_valid_i,
   output logic [1:0]          req_ready_o,
   input  md_op_e              req_op_i [2],
   input  logic [1:0]          req_signed_i [2],
   input  logic [31:0]         req_a_i [2],
   input  logic [31:0]         req_b_i [2],
   output logic [1:0]          rsp_valid_o,
   input  logic [1:0]          rsp_ready_i,
   output logic [31:0]         rsp_result_o,
   output logic                md_mult_en_o,
   output logic                md_div_en_o,
   output logic                md_mult_sel_o,
   output logic                md_div_sel_o,
   output md_op_e              md_operator_o,
   output logic [1:0]          md_signed_mode_o,
   output logic [31:0]         md_op_a_o,
   output logic [31:0]         md_op_b_o,
   output logic                md_ready_id_o,
   input  logic                md_valid_i,
   input  logic [31:0]         md_result_i,
   input  logic [33:0]         md_imd_val_d_i [2],
   input  logic [1:0]          md_imd_val_we_i,
   output logic [33:0]         md_imd_val_q_o [2],
   output logic [31:0]         perf_ops_o,
   output logic [31:0]         perf_busy_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_RESP = 2'b10
   } state_e;

   state_e       r_state;
   logic         r_last;      // index of the requester granted most recently
   logic         r_owner;     // index of the requester whose op is in flight
   md_op_e       r_op;
   logic [1:0]   r_signed;
   logic [31:0]  r_a;
   logic [31:0]  r_b;
   logic [31:0]  r_result;
   logic [1:0]   r_rsp_valid;
   logic         r_mult_en;
   logic         r_div_en;
   logic         r_ready_id;
   logic [33:0]  r_imd [2];

   logic [1:0]   w_grant;
   logic         w_sel;
   logic         w_hs;
   logic         w_is_mult;
   logic         w_rsp_hs;

   // Pick the winner among valid requesters; only IDLE may grant.
   always_comb begin
      w_grant = 2'b00;
      if (r_state == S_IDLE) begin
         if (FixedPrio) begin
            w_grant = req_valid_i[0] ? 2'b01 : {req_valid_i[1], 1'b0};
         end else if (&req_valid_i) begin
            w_grant = r_last ? 2'b01 : 2'b10;
         end else begin
            w_grant = req_valid_i;
         end
      end
   end

   assign w_sel     = w_grant[1];
   assign w_hs      = |w_grant;
   assign w_is_mult = (req_op_i[w_sel] == MD_OP_MULL) || (req_op_i[w_sel] == MD_OP_MULH);
   assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready_i[r_owner];

   assign req_ready_o      = w_grant;
   assign rsp_valid_o      = r_rsp_valid;
   assign rsp_result_o     = r_result;
   assign md_mult_en_o     = r_mult_en;
   assign md_mult_sel_o    = r_mult_en;
   assign md_div_en_o      = r_div_en;
   assign md_div_sel_o     = r_div_en;
   assign md_ready_id_o    = r_ready_id;
   assign md_operator_o    = r_op;
   assign md_signed_mode_o = r_signed;
   assign md_op_a_o        = r_a;
   assign md_op_b_o        = r_b;
   assign md_imd_val_q_o   = r_imd;

   // Control FSM: latch on grant, drive the multdiv while BUSY, hold the result in RESP.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_last      <= 1'b1;
         r_owner     <= 1'b0;
         r_op        <= MD_OP_MULL;
         r_signed    <= 2'b00;
         r_a         <= 32'd0;
         r_b         <= 32'd0;
         r_result    <= 32'd0;
         r_rsp_valid <= 2'b00;
         r_mult_en   <= 1'b0;
         r_div_en    <= 1'b0;
         r_ready_id  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_op       <= req_op_i[w_sel];
                  r_signed   <= req_signed_i[w_sel];
                  r_a        <= req_a_i[w_sel];
                  r_b        <= req_b_i[w_sel];
                  r_owner    <= w_sel;
                  r_last     <= w_sel;
                  r_mult_en  <= w_is_mult;
                  r_div_en   <= ~w_is_mult;
                  r_ready_id <= 1'b1;
                  r_state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (md_valid_i) begin
                  r_result    <= md_result_i;
                  r_mult_en   <= 1'b0;
                  r_div_en    <= 1'b0;
                  r_ready_id  <= 1'b0;
                  r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (w_rsp_hs) begin
                  r_rsp_valid <= 2'b00;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 2'b00;
               r_mult_en   <= 1'b0;
               r_div_en    <= 1'b0;
               r_ready_id  <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   // Intermediate value storage for the multdiv, writable in any state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_imd[0] <= 34'd0;
         r_imd[1] <= 34'd0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (md_imd_val_we_i[i]) r_imd[i] <= md_imd_val_d_i[i];
         end
      end
   end

`ifdef IBEX_MD_ARB_PERF_EN
   logic [31:0] r_perf_ops;
   logic [31:0] r_perf_busy;

   // Count completed ops and BUSY cycles; both wrap naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_perf_ops  <= 32'd0;
         r_perf_busy <= 32'd0;
      end else begin
         if (w_rsp_hs)            r_perf_ops  <= r_perf_ops + 32'd1;
         if (r_state == S_BUSY)   r_perf_busy <= r_perf_busy + 32'd1;
      end
   end

   assign perf_ops_o  = r_perf_ops;
   assign perf_busy_o = r_perf_busy;
`else
   assign perf_ops_o  = 32'd0;
   assign perf_busy_o = 32'd0;
`endif

endmodule
